// File: rtl/map_dlatch_core.sv
// Discrete-latch bank register for single-register NES mappers.
// M2 synchronised write capture, PRG/CHR window decode and save-state port.
module map_dlatch_core #(
    parameter int PRG_BITS     = 4,
    parameter int CHR_BITS     = 4,
    parameter int CHR_LSB      = 4,
    parameter int MIR_BIT      = 8,
    parameter int PRG_MODE     = 0,
    parameter int CHR_MODE     = 0,
    parameter int BUS_CONFLICT = 0,
    localparam int CHR_AW      = (CHR_BITS + 13 > 16) ? CHR_BITS + 13 : 16
) (
    input  logic                  clk,
    input  logic                  map_rst,
    input  logic                  m2,
    input  logic [15:0]           cpu_addr,
    input  logic [7:0]            cpu_dat,
    input  logic                  cpu_rw,
    input  logic [7:0]            rom_dout,
    input  logic [13:0]           ppu_addr,
    input  logic                  ss_act,
    input  logic                  ss_we,
    input  logic [7:0]            ss_addr,
    input  logic [7:0]            ss_wdat,
    output logic [PRG_BITS+14:0]  prg_addr,
    output logic [CHR_AW-1:0]     chr_addr,
    output logic                  chr_ram_ce,
    output logic                  ciram_ce,
    output logic                  ciram_a10,
    output logic [7:0]            ss_rdat,
    output logic                  reg_upd
);

    localparam logic [5:0] PRG_MASK = 6'((1 << PRG_BITS) - 1);
    localparam logic [3:0] CHR_MASK = 4'((1 << CHR_BITS) - 1);

    logic       m2_s1, m2_s2, m2_f, armed;
    logic [1:0] vld;
    logic       cap_a15, cap_rw;
    logic [7:0] cap_dat, cap_rom;
    logic [5:0] prg_r;
    logic [3:0] chr_r;
    logic       mir_r;

    logic       m2_lo, m2_hi, m2_fall, cpu_wr, ss_wr;
    logic [7:0] d;
    logic [5:0] prg_new;
    logic [3:0] chr_new;
    logic       mir_new;

    // Filtered level: a fall needs two consecutive low samples, a rise
    // needs two highs, and a rise only counts after a low has been seen.
    assign m2_lo   = vld[1] & ~m2_s1 & ~m2_s2;
    assign m2_hi   = vld[1] & m2_s1 & m2_s2;
    assign m2_fall = m2_f & m2_lo;
    assign cpu_wr  = m2_fall & cap_a15 & ~cap_rw & ~ss_act;
    assign ss_wr   = ss_act & ss_we & (ss_addr == 8'd0 || ss_addr == 8'd1);

    assign d       = (BUS_CONFLICT != 0) ? (cap_dat & cap_rom) : cap_dat;
    assign prg_new = 6'(d & 8'(PRG_MASK));
    assign chr_new = 4'((d >> CHR_LSB) & 8'(CHR_MASK));
    assign mir_new = 1'((d >> MIR_BIT) & 8'h01);

    always_ff @(posedge clk) begin
        if (map_rst) begin
            m2_s1   <= 1'b0;
            m2_s2   <= 1'b0;
            m2_f    <= 1'b0;
            armed   <= 1'b0;
            vld     <= 2'b00;
            cap_a15 <= 1'b0;
            cap_rw  <= 1'b1;
            cap_dat <= 8'h00;
            cap_rom <= 8'h00;
            prg_r   <= 6'h00;
            chr_r   <= 4'h0;
            mir_r   <= 1'b0;
            reg_upd <= 1'b0;
            ss_rdat <= 8'hFF;
        end else begin
            m2_s1   <= m2;
            m2_s2   <= m2_s1;
            vld     <= {vld[0], 1'b1};
            reg_upd <= cpu_wr | ss_wr;
            if (m2_lo)
                armed <= 1'b1;
            if (m2_hi && armed)
                m2_f <= 1'b1;
            else if (m2_lo)
                m2_f <= 1'b0;
            if (m2_s2 && armed) begin
                cap_a15 <= cpu_addr[15];
                cap_rw  <= cpu_rw;
                cap_dat <= cpu_dat;
                cap_rom <= rom_dout;
            end
            if (ss_wr) begin
                if (!ss_addr[0]) begin
                    chr_r        <= ss_wdat[7:4] & CHR_MASK;
                    prg_r[3:0]   <= ss_wdat[3:0] & PRG_MASK[3:0];
                end else begin
                    mir_r        <= ss_wdat[3];
                    prg_r[5:4]   <= ss_wdat[1:0] & PRG_MASK[5:4];
                end
            end else if (cpu_wr) begin
                prg_r <= prg_new;
                chr_r <= chr_new;
                if (MIR_BIT < 8)
                    mir_r <= mir_new;
            end
            if (!ss_act)
                ss_rdat <= 8'hFF;
            else if (ss_addr == 8'd0)
                ss_rdat <= {chr_r, prg_r[3:0]};
            else if (ss_addr == 8'd1)
                ss_rdat <= {4'h0, mir_r, 1'b0, prg_r[5:4]};
            else
                ss_rdat <= 8'hFF;
        end
    end

    logic [20:0] prg_full;
    logic [5:0]  prg_bank;

    always_comb begin
        prg_bank = cpu_addr[14] ? PRG_MASK : prg_r;
        if (PRG_MODE == 0)
            prg_full = {prg_r, cpu_addr[14:0]};
        else
            prg_full = {1'b0, prg_bank, cpu_addr[13:0]};
    end

    assign prg_addr = prg_full[PRG_BITS+14:0];

    logic [16:0] chr_full;
    logic [1:0]  ram_sel;
    logic        nt_ciram, pt_rom;

    assign nt_ciram = ppu_addr[13] & ppu_addr[11];
    assign pt_rom   = ~ppu_addr[13] & (ppu_addr[12:11] == 2'b00);
    assign ram_sel  = ppu_addr[13] ? 2'b00 : ppu_addr[12:11];

    always_comb begin
        chr_full   = {chr_r, ppu_addr[12:0]};
        chr_ram_ce = 1'b0;
        ciram_ce   = ~ppu_addr[13];
        if (CHR_MODE != 0) begin
            unique case (1'b1)
                nt_ciram: begin
                    chr_full = {6'h10, ppu_addr[10:0]};
                    ciram_ce = 1'b0;
                end
                pt_rom: begin
                    chr_full = {2'b00, chr_r, ppu_addr[10:0]};
                    ciram_ce = 1'b1;
                end
                default: begin
                    chr_full   = {4'b0100, ram_sel, ppu_addr[10:0]};
                    chr_ram_ce = 1'b1;
                    ciram_ce   = 1'b1;
                end
            endcase
        end
    end

    assign chr_addr  = chr_full[CHR_AW-1:0];
    assign ciram_a10 = (MIR_BIT < 8) ? mir_r : ppu_addr[10];

endmodule

// File: tb/tb_map_dlatch_core.sv
// Bench for map_dlatch_core: a plain 32K/8K instance and a
// 16K-fixed / CHR-RAM / bus-conflict / single-screen instance.
module tb_map_dlatch_core;

    logic        clk = 1'b0;
    logic        map_rst;
    logic        m2;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic        cpu_rw;
    logic [7:0]  rom_dout;
    logic [13:0] ppu_addr;
    logic        ss_act, ss_we;
    logic [7:0]  ss_addr, ss_wdat;

    logic [18:0] p0, p1;
    logic [16:0] c0, c1;
    logic        rce0, rce1, cce0, cce1, a10_0, a10_1, upd0, upd1;
    logic [7:0]  rd0, rd1;

    int n_checks = 0;
    int n_errs   = 0;
    int cnt0 = 0;
    int cnt1 = 0;

    // reference state
    int m_prg0, m_chr0, m_prg1, m_chr1, m_mir1;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upd0) cnt0++;
        if (upd1) cnt1++;
    end

    map_dlatch_core u0 (
        .clk(clk), .map_rst(map_rst), .m2(m2),
        .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .cpu_rw(cpu_rw),
        .rom_dout(rom_dout), .ppu_addr(ppu_addr),
        .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
        .ss_wdat(ss_wdat), .prg_addr(p0), .chr_addr(c0),
        .chr_ram_ce(rce0), .ciram_ce(cce0), .ciram_a10(a10_0),
        .ss_rdat(rd0), .reg_upd(upd0)
    );

    map_dlatch_core #(
        .MIR_BIT(7), .PRG_MODE(1), .CHR_MODE(1), .BUS_CONFLICT(1)
    ) u1 (
        .clk(clk), .map_rst(map_rst), .m2(m2),
        .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .cpu_rw(cpu_rw),
        .rom_dout(rom_dout), .ppu_addr(ppu_addr),
        .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
        .ss_wdat(ss_wdat), .prg_addr(p1), .chr_addr(c1),
        .chr_ram_ce(rce1), .ciram_ce(cce1), .ciram_a10(a10_1),
        .ss_rdat(rd1), .reg_upd(upd1)
    );

    task automatic mdl_reset();
        m_prg0 = 0; m_chr0 = 0; m_prg1 = 0; m_chr1 = 0; m_mir1 = 0;
    endtask

    task automatic mdl_cpu(input int a, input int dt, input bit rw,
                           input int rom);
        int d1;
        if (a >= 'h8000 && !rw && !ss_act) begin
            d1 = dt & rom;
            m_prg0 = dt % 16;
            m_chr0 = (dt / 16) % 16;
            m_prg1 = d1 % 16;
            m_chr1 = (d1 / 16) % 16;
            m_mir1 = d1 / 128;
        end
    endtask

    task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] dt,
                             input logic rw, input logic [7:0] rom);
        @(negedge clk);
        cpu_addr = a; cpu_dat = dt; cpu_rw = rw; rom_dout = rom;
        m2 = 1'b1;
        repeat (4) @(negedge clk);
        m2 = 1'b0;
        repeat (5) @(negedge clk);
        mdl_cpu(a, dt, rw, rom);
    endtask

    task automatic test_reset();
        map_rst = 1'b1; m2 = 1'b0; cpu_addr = 16'hC123; cpu_dat = 8'h00;
        cpu_rw = 1'b1; rom_dout = 8'hFF; ppu_addr = 14'h0123;
        ss_act = 1'b0; ss_we = 1'b0; ss_addr = 8'h00; ss_wdat = 8'h00;
        mdl_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (p0 !== 19'h04123) begin
            n_errs++;
            $display("FAIL reset_prg0 got %h want %h", p0, 19'h04123);
        end
        n_checks++;
        if (p1 !== 19'h3C123) begin
            n_errs++;
            $display("FAIL reset_prg1 got %h want %h", p1, 19'h3C123);
        end
        n_checks++;
        if (c0 !== 17'h00123 || cce0 !== 1'b1 || rce0 !== 1'b0) begin
            n_errs++;
            $display("FAIL reset_chr0 got %h/%b/%b want 00123/1/0",
                     c0, cce0, rce0);
        end
        n_checks++;
        if (rd0 !== 8'hFF || upd0 !== 1'b0 || a10_1 !== 1'b0) begin
            n_errs++;
            $display("FAIL reset_misc got rd=%h upd=%b a10=%b want ff/0/0",
                     rd0, upd0, a10_1);
        end
        map_rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_decode();
        int base;
        base = cnt0;
        @(negedge clk);
        cpu_addr = 16'h8000; cpu_dat = 8'h35; cpu_rw = 1'b0;
        rom_dout = 8'hFF; m2 = 1'b1;
        repeat (4) @(negedge clk);
        m2 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (upd0 !== 1'b0) begin
            n_errs++;
            $display("FAIL upd_early got %b want 0", upd0);
        end
        @(negedge clk);
        n_checks++;
        if (upd0 !== 1'b1) begin
            n_errs++;
            $display("FAIL upd_latency got %b want 1", upd0);
        end
        repeat (3) @(negedge clk);
        mdl_cpu('h8000, 'h35, 1'b0, 'hFF);
        cpu_addr = 16'hC123; ppu_addr = 14'h0456; #1;
        n_checks++;
        if (p0 !== 19'h2C123) begin
            n_errs++;
            $display("FAIL wr35_prg got %h want %h", p0, 19'h2C123);
        end
        n_checks++;
        if (c0 !== 17'h06456) begin
            n_errs++;
            $display("FAIL wr35_chr got %h want %h", c0, 17'h06456);
        end
        n_checks++;
        if (cnt0 - base !== 1) begin
            n_errs++;
            $display("FAIL wr35_upd_pulses got %0d want 1", cnt0 - base);
        end
    endtask

    task automatic test_bus_conflict();
        cpu_cycle(16'h8000, 8'hFF, 1'b0, 8'h12);
        cpu_addr = 16'h8000; ppu_addr = 14'h0400; #1;
        n_checks++;
        if (p1 !== 19'h08000 || c1 !== 17'h00C00) begin
            n_errs++;
            $display("FAIL bus_conflict got %h/%h want 08000/00c00", p1, c1);
        end
        cpu_addr = 16'hC123; #1;
        n_checks++;
        if (p0 !== 19'h7C123) begin
            n_errs++;
            $display("FAIL no_conflict got %h want %h", p0, 19'h7C123);
        end
    endtask

    task automatic test_prg_mode1();
        cpu_cycle(16'hFFFF, 8'h03, 1'b0, 8'hFF);
        cpu_addr = 16'h8010; #1;
        n_checks++;
        if (p1 !== 19'h0C010) begin
            n_errs++;
            $display("FAIL prg16_low got %h want %h", p1, 19'h0C010);
        end
        cpu_addr = 16'hC010; #1;
        n_checks++;
        if (p1 !== 19'h3C010) begin
            n_errs++;
            $display("FAIL prg16_fixed got %h want %h", p1, 19'h3C010);
        end
    endtask

    task automatic test_chr_mode1();
        cpu_cycle(16'h9000, 8'h20, 1'b0, 8'hFF);
        ppu_addr = 14'h0400; #1;
        n_checks++;
        if (c1 !== 17'h01400 || rce1 !== 1'b0 || cce1 !== 1'b1) begin
            n_errs++;
            $display("FAIL chr2k_rom got %h/%b/%b want 01400/0/1",
                     c1, rce1, cce1);
        end
        ppu_addr = 14'h1800; #1;
        n_checks++;
        if (c1 !== 17'h09800 || rce1 !== 1'b1) begin
            n_errs++;
            $display("FAIL chr_ram got %h/%b want 09800/1", c1, rce1);
        end
        ppu_addr = 14'h2C00; #1;
        n_checks++;
        if (cce1 !== 1'b0 || rce1 !== 1'b0) begin
            n_errs++;
            $display("FAIL nt_ciram got ce=%b ram=%b want 0/0", cce1, rce1);
        end
        ppu_addr = 14'h3400; #1;
        n_checks++;
        if (c1 !== 17'h08400 || rce1 !== 1'b1 || cce1 !== 1'b1) begin
            n_errs++;
            $display("FAIL nt_ram got %h/%b/%b want 08400/1/1",
                     c1, rce1, cce1);
        end
    endtask

    task automatic test_mirror();
        cpu_cycle(16'h8000, 8'h80, 1'b0, 8'hFF);
        ppu_addr = 14'h2000; #1;
        n_checks++;
        if (a10_1 !== 1'b1 || a10_0 !== 1'b0) begin
            n_errs++;
            $display("FAIL mirror_a got %b/%b want 1/0", a10_1, a10_0);
        end
        ppu_addr = 14'h2400; #1;
        n_checks++;
        if (a10_1 !== 1'b1 || a10_0 !== 1'b1) begin
            n_errs++;
            $display("FAIL mirror_b got %b/%b want 1/1", a10_1, a10_0);
        end
    endtask

    task automatic test_ignored();
        int base;
        base = cnt0;
        cpu_cycle(16'h8000, 8'h11, 1'b1, 8'hFF);
        cpu_cycle(16'h7FFF, 8'h22, 1'b0, 8'hFF);
        cpu_addr = 16'h8123; #1;
        n_checks++;
        if (p0 !== 19'h00123 || cnt0 - base !== 0) begin
            n_errs++;
            $display("FAIL ignored got %h upd=%0d want 00123 upd=0",
                     p0, cnt0 - base);
        end
    endtask

    task automatic test_glitch();
        int base;
        base = cnt0;
        @(negedge clk);
        cpu_addr = 16'h8000; cpu_dat = 8'h69; cpu_rw = 1'b0;
        rom_dout = 8'hFF; m2 = 1'b1;
        repeat (4) @(negedge clk);
        m2 = 1'b0;
        @(negedge clk);
        m2 = 1'b1;
        repeat (4) @(negedge clk);
        m2 = 1'b0;
        repeat (6) @(negedge clk);
        mdl_cpu('h8000, 'h69, 1'b0, 'hFF);
        cpu_addr = 16'h8000; #1;
        n_checks++;
        if (cnt0 - base !== 1 || p0 !== 19'h48000) begin
            n_errs++;
            $display("FAIL glitch got upd=%0d prg=%h want 1/48000",
                     cnt0 - base, p0);
        end
    endtask

    task automatic test_save_state();
        int base;
        base = cnt0;
        @(negedge clk);
        ss_act = 1'b1; ss_we = 1'b1; ss_addr = 8'h00; ss_wdat = 8'hA7;
        @(negedge clk);
        ss_we = 1'b0;
        m_prg0 = 7; m_chr0 = 10; m_prg1 = 7; m_chr1 = 10;
        cpu_cycle(16'h8000, 8'h00, 1'b0, 8'hFF);
        cpu_addr = 16'hC123; ppu_addr = 14'h0123; #1;
        n_checks++;
        if (p0 !== 19'h3C123 || c0 !== 17'h14123) begin
            n_errs++;
            $display("FAIL ss_load got %h/%h want 3c123/14123", p0, c0);
        end
        n_checks++;
        if (cnt0 - base !== 1) begin
            n_errs++;
            $display("FAIL ss_upd got %0d want 1", cnt0 - base);
        end
        @(negedge clk);
        n_checks++;
        if (rd0 !== 8'hA7 || rd1 !== 8'hA7) begin
            n_errs++;
            $display("FAIL ss_read0 got %h/%h want a7", rd0, rd1);
        end
        ss_we = 1'b1; ss_addr = 8'h01; ss_wdat = 8'h09;
        @(negedge clk);
        ss_we = 1'b0;
        m_mir1 = 1;
        @(negedge clk);
        n_checks++;
        if (rd0 !== 8'h08 || a10_1 !== 1'b1) begin
            n_errs++;
            $display("FAIL ss_read1 got %h a10=%b want 08/1", rd0, a10_1);
        end
        ss_addr = 8'h05;
        @(negedge clk);
        n_checks++;
        if (rd1 !== 8'hFF) begin
            n_errs++;
            $display("FAIL ss_other got %h want ff", rd1);
        end
        ss_act = 1'b0; ss_addr = 8'h00;
        @(negedge clk);
        n_checks++;
        if (rd0 !== 8'hFF) begin
            n_errs++;
            $display("FAIL ss_idle got %h want ff", rd0);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        cpu_cycle(16'h8000, 8'hFF, 1'b0, 8'hFF);
        base = cnt0;
        @(negedge clk);
        cpu_addr = 16'h8000; cpu_dat = 8'h55; cpu_rw = 1'b0;
        rom_dout = 8'hFF; m2 = 1'b1;
        repeat (3) @(negedge clk);
        map_rst = 1'b1;
        @(negedge clk);
        map_rst = 1'b0;
        mdl_reset();
        repeat (2) @(negedge clk);
        m2 = 1'b0;
        repeat (6) @(negedge clk);
        cpu_addr = 16'hC123; ppu_addr = 14'h2400; #1;
        n_checks++;
        if (p0 !== 19'h04123 || p1 !== 19'h3C123 || a10_1 !== 1'b0) begin
            n_errs++;
            $display("FAIL rst_mid_banks got %h/%h/%b want 04123/3c123/0",
                     p0, p1, a10_1);
        end
        n_checks++;
        if (cnt0 - base !== 0) begin
            n_errs++;
            $display("FAIL rst_mid_commit got %0d want 0", cnt0 - base);
        end
        cpu_cycle(16'h8000, 8'h55, 1'b0, 8'hFF);
        cpu_addr = 16'hC123; #1;
        n_checks++;
        if (p0 !== 19'h2C123 || cnt0 - base !== 1) begin
            n_errs++;
            $display("FAIL rst_fresh got %h upd=%0d want 2c123/1",
                     p0, cnt0 - base);
        end
    endtask

    task automatic test_random();
        int a, dt, rom, pa, b0, b1, e_c1, e_cce1, e_rce1, e_p1;
        bit rw;
        for (int i = 0; i < 40; i++) begin
            a   = $urandom_range(0, 'hFFFF);
            dt  = $urandom_range(0, 255);
            rom = $urandom_range(0, 255);
            rw  = ($urandom_range(0, 3) == 0);
            b0 = cnt0; b1 = cnt1;
            cpu_cycle(16'(a), 8'(dt), rw, 8'(rom));
            n_checks++;
            if (cnt0 - b0 !== ((a >= 'h8000 && !rw) ? 1 : 0) ||
                cnt1 - b1 !== cnt0 - b0) begin
                n_errs++;
                $display("FAIL rnd_upd a=%h rw=%b got %0d/%0d",
                         a, rw, cnt0 - b0, cnt1 - b1);
            end
            for (int k = 0; k < 3; k++) begin
                a  = $urandom_range(0, 'hFFFF);
                pa = $urandom_range(0, 'h3FFF);
                cpu_addr = 16'(a); ppu_addr = 14'(pa); #1;
                e_p1 = ((a % 'h8000) >= 'h4000 ? 15 : m_prg1) * 'h4000
                       + a % 'h4000;
                e_rce1 = 0; e_cce1 = 1; e_c1 = 0;
                if (pa < 'h800) e_c1 = m_chr1 * 'h800 + pa;
                else if (pa < 'h2000) begin e_c1 = 'h8000 + pa; e_rce1 = 1; end
                else if (((pa / 'h800) % 2) == 0) begin
                    e_c1 = 'h8000 + pa % 'h800; e_rce1 = 1;
                end else e_cce1 = 0;
                n_checks++;
                if (p0 !== 19'(m_prg0 * 'h8000 + a % 'h8000) ||
                    p1 !== 19'(e_p1)) begin
                    n_errs++;
                    $display("FAIL rnd_prg a=%h got %h/%h want %h/%h", a, p0,
                             p1, 19'(m_prg0 * 'h8000 + a % 'h8000), 19'(e_p1));
                end
                n_checks++;
                if (c0 !== 17'(m_chr0 * 'h2000 + pa % 'h2000) ||
                    cce0 !== (pa < 'h2000) || a10_0 !== 1'((pa / 'h400) % 2)) begin
                    n_errs++;
                    $display("FAIL rnd_chr0 pa=%h got %h/%b/%b", pa, c0,
                             cce0, a10_0);
                end
                n_checks++;
                if (rce1 !== 1'(e_rce1) || cce1 !== 1'(e_cce1) ||
                    (e_cce1 == 1 && c1 !== 17'(e_c1)) ||
                    a10_1 !== 1'(m_mir1)) begin
                    n_errs++;
                    $display("FAIL rnd_chr1 pa=%h got %h/%b/%b/%b want %h/%0d/%0d/%0d",
                             pa, c1, rce1, cce1, a10_1, 17'(e_c1), e_rce1,
                             e_cce1, m_mir1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_decode();
        test_bus_conflict();
        test_prg_mode1();
        test_chr_mode1();
        test_mirror();
        test_ignored();
        test_glitch();
        test_save_state();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
